// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM encoding and the
// width of the products coming from the 2x2 multiplier.
package product_accumulator_pkg;

    localparam int PRODUCT_WIDTH = 4;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier side, the accumulator and its consumer.
// The master drives terms and consumes results; the slave is the accumulator.
interface product_accumulator_if
    import product_accumulator_pkg::*;
#(
    parameter int ACC_WIDTH = 8
);

    logic                     clear;
    logic                     in_valid;
    logic                     in_ready;
    logic [PRODUCT_WIDTH-1:0] in_product;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_WIDTH-1:0]     out_sum;
    logic                     out_overflow;

    modport master (
        output clear, in_valid, in_product, out_ready,
        input  in_ready, out_valid, out_sum, out_overflow
    );

    modport slave (
        input  clear, in_valid, in_product, out_ready,
        output in_ready, out_valid, out_sum, out_overflow
    );

endinterface

// File: rtl/adder_ripple_nbit.sv
// WIDTH-bit ripple-carry adder assembled from one full-adder cell per bit;
// the carry out of the top cell is exported for overflow tracking.
module adder_ripple_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign carry_out = carry[WIDTH];

endmodule

// File: rtl/product_accumulator.sv
// Sums TERMS multiplier products into an ACC_WIDTH accumulator and hands the
// result, with a sticky carry-out flag, to a valid/ready consumer.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int ACC_WIDTH = 8,
    parameter int TERMS     = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    product_accumulator_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TERMS - 1);

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic                 out_overflow_q, out_overflow_d;

    logic [ACC_WIDTH-1:0] product_ext;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_carry;
    logic                 in_ready;
    logic                 accept;

    always_comb begin
        product_ext                    = '0;
        product_ext[PRODUCT_WIDTH-1:0] = bus.in_product;
    end

    adder_ripple_nbit #(
        .WIDTH (ACC_WIDTH)
    ) u_adder (
        .a         (acc_q),
        .b         (product_ext),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    assign in_ready = (state_q == ST_ACCUM) && !bus.clear;
    assign accept   = in_ready && bus.in_valid;

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        count_d        = count_q;
        overflow_d     = overflow_q;
        out_valid_d    = out_valid_q;
        out_sum_d      = out_sum_q;
        out_overflow_d = out_overflow_q;

        case (state_q)
            ST_ACCUM: begin
                if (bus.clear) begin
                    acc_d      = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else if (accept) begin
                    if (count_q == LAST_CNT) begin
                        // Final term: publish and restart the running sum for the next result.
                        out_sum_d      = add_sum;
                        out_overflow_d = overflow_q | add_carry;
                        out_valid_d    = 1'b1;
                        acc_d          = '0;
                        count_d        = '0;
                        overflow_d     = 1'b0;
                        state_d        = ST_HOLD;
                    end else begin
                        acc_d      = add_sum;
                        overflow_d = overflow_q | add_carry;
                        count_d    = count_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_HOLD: begin
                // clear drops the held result even when the consumer is ready.
                if (bus.clear || bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_ACCUM;
            acc_q          <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            out_valid_q    <= out_valid_d;
            out_sum_q      <= out_sum_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = out_sum_q;
    assign bus.out_overflow = out_overflow_q;

endmodule
